// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: issues data-memory requests over req/ack, stalls
// until completion or timeout, and registers the lane-aligned writeback bundle.
module mem_lsu #(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [4:0]  wb_rd,
    output logic [2:0]  wb_funct3,
    output logic [31:0] wb_data,
    output logic        misalign_exc,
    output logic        timeout_exc
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       off;
    logic             mem_op, size_ok, align_ok, access_ok;
    logic             misalign, timeout_hit;

    assign off    = ex_addr[1:0];
    assign mem_op = ex_valid & (ex_mem_read | ex_mem_write);

    // Store wins when both read and write are flagged, so it selects the legal codes.
    always_comb begin
        size_ok  = 1'b0;
        align_ok = 1'b0;
        if (ex_mem_write)
            size_ok = ex_funct3 inside {3'b000, 3'b001, 3'b010};
        else
            size_ok = ex_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        case (ex_funct3[1:0])
            2'b00:   align_ok = 1'b1;
            2'b01:   align_ok = ~off[0];
            2'b10:   align_ok = (off == 2'b00);
            default: align_ok = 1'b0;
        endcase
    end

    assign access_ok   = size_ok & align_ok;
    assign mem_req     = ~rst & mem_op & access_ok;
    assign misalign    = mem_op & ~access_ok;
    assign timeout_hit = mem_req & (state == BUSY) & (cnt == CNT_LAST) & ~mem_ack;
    assign stall       = mem_req & ~mem_ack & ~timeout_hit;
    assign mem_we      = ex_mem_write;
    assign mem_addr    = {ex_addr[31:2], 2'b00};

    always_comb begin
        mem_be    = 4'b1111;
        mem_wdata = ex_wdata;
        if (ex_mem_write) begin
            case (ex_funct3[1:0])
                2'b00: begin
                    mem_be    = 4'b0001 << off;
                    mem_wdata = {4{ex_wdata[7:0]}};
                end
                2'b01: begin
                    mem_be    = 4'b0011 << off;
                    mem_wdata = {2{ex_wdata[15:0]}};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: if (mem_req && !mem_ack) begin
                state_nxt = BUSY;
                cnt_nxt   = '0;
            end
            BUSY: begin
                if (!mem_req || mem_ack || timeout_hit) state_nxt = IDLE;
                else                                    cnt_nxt   = cnt + CNT_W'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_rd        <= '0;
            wb_funct3    <= '0;
            wb_data      <= '0;
            misalign_exc <= 1'b0;
            timeout_exc  <= 1'b0;
        end else begin
            misalign_exc <= 1'b0;
            timeout_exc  <= 1'b0;
            if (timeout_hit) begin
                wb_valid     <= 1'b1;
                wb_reg_write <= 1'b0;
                timeout_exc  <= 1'b1;
            end else if (misalign) begin
                wb_valid     <= 1'b1;
                wb_reg_write <= 1'b0;
                misalign_exc <= 1'b1;
            end else if (stall) begin
                wb_valid <= 1'b0;
            end else begin
                wb_valid <= ex_valid;
                wb_rd    <= ex_rd;
                if (ex_mem_write) begin
                    wb_reg_write <= 1'b0;
                    wb_data      <= '0;
                    wb_funct3    <= ex_funct3;
                end else if (ex_mem_read) begin
                    wb_reg_write <= ex_valid & ex_reg_write;
                    wb_data      <= mem_rdata >> {off, 3'b000};
                    wb_funct3    <= ex_funct3;
                end else begin
                    wb_reg_write <= ex_valid & ex_reg_write;
                    wb_data      <= ex_addr;
                    wb_funct3    <= 3'b010;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_lsu.sv
// Directed plus randomized bench for mem_lsu against a byte-level access model.
module tb_mem_lsu;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr, ex_wdata;
    logic [4:0]  ex_rd;
    logic        stall, mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        wb_valid, wb_reg_write, misalign_exc, timeout_exc;
    logic [4:0]  wb_rd;
    logic [2:0]  wb_funct3;
    logic [31:0] wb_data;

    int checks = 0;
    int errors = 0;

    mem_lsu #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .wb_funct3(wb_funct3), .wb_data(wb_data),
        .misalign_exc(misalign_exc), .timeout_exc(timeout_exc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Access model: sizes in bytes, legality by divisibility, lanes by byte loops.
    function automatic int unsigned nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit model_ok(input bit wr, input logic [2:0] f3, input int unsigned off);
        if (wr) begin
            if (f3 > 3'd2) return 1'b0;
        end else if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) begin
            return 1'b0;
        end
        return (off % nbytes(f3)) == 0;
    endfunction

    function automatic logic [3:0] model_be(input bit wr, input logic [2:0] f3, input int unsigned off);
        logic [3:0] be;
        if (!wr) return 4'hF;
        be = 4'h0;
        for (int i = 0; i < 4; i++)
            if (i >= off && i < off + nbytes(f3)) be[i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input bit wr, input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] o;
        int unsigned n;
        if (!wr) return wd;
        n = nbytes(f3);
        for (int i = 0; i < 4; i++) o[8*i +: 8] = wd[8*(i % n) +: 8];
        return o;
    endfunction

    task automatic do_op(input bit v, input bit rd_e, input bit wr_e, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                         input bit rw, input logic [31:0] rdata, input int waits);
        int unsigned off;
        int nst;
        off = addr % 4;
        @(negedge clk);
        ex_valid = v; ex_mem_read = rd_e; ex_mem_write = wr_e; ex_funct3 = f3;
        ex_addr = addr; ex_wdata = wd; ex_rd = rd; ex_reg_write = rw;
        mem_rdata = rdata; mem_ack = 1'b0;
        #1;
        if (!(v && (rd_e || wr_e))) begin
            chk("req_nomem", mem_req, 0);
            chk("stall_nomem", stall, 0);
            @(posedge clk); #1;
            chk("wbv_nomem", wb_valid, v);
            chk("wbrw_nomem", wb_reg_write, v & rw);
            if (v) begin
                chk("wbdata_alu", wb_data, addr);
                chk("wbf3_alu", wb_funct3, 3'b010);
                chk("wbrd_alu", wb_rd, rd);
            end
        end else if (!model_ok(wr_e, f3, off)) begin
            chk("req_mis", mem_req, 0);
            chk("stall_mis", stall, 0);
            @(posedge clk); #1;
            chk("exc_mis", misalign_exc, 1);
            chk("wbv_mis", wb_valid, 1);
            chk("wbrw_mis", wb_reg_write, 0);
            @(negedge clk); ex_valid = 1'b0;
            @(posedge clk); #1;
            chk("exc_mis_pulse", misalign_exc, 0);
        end else begin
            chk("req", mem_req, 1);
            chk("we", mem_we, wr_e);
            chk("addr", mem_addr, addr & 32'hFFFF_FFFC);
            chk("be", mem_be, model_be(wr_e, f3, off));
            if (wr_e) chk("wdata", mem_wdata, model_wdata(wr_e, f3, wd));
            nst = (waits > TO) ? TO : waits;
            for (int w = 0; w < nst; w++) begin
                chk("stall_wait", stall, 1);
                @(posedge clk); #1;
                chk("wbv_bubble", wb_valid, 0);
                @(negedge clk); #1;
            end
            if (waits > TO) begin
                chk("stall_to", stall, 0);
                @(posedge clk); #1;
                chk("exc_to", timeout_exc, 1);
                chk("wbv_to", wb_valid, 1);
                chk("wbrw_to", wb_reg_write, 0);
                @(negedge clk); ex_valid = 1'b0;
                @(posedge clk); #1;
                chk("exc_to_pulse", timeout_exc, 0);
                chk("stall_after_to", stall, 0);
            end else begin
                mem_ack = 1'b1;
                #1;
                chk("stall_ack", stall, 0);
                @(posedge clk); #1;
                chk("wbv_done", wb_valid, 1);
                chk("wbrd_done", wb_rd, rd);
                chk("exc_to_none", timeout_exc, 0);
                if (wr_e) begin
                    chk("wbrw_st", wb_reg_write, 0);
                    chk("wbdata_st", wb_data, 0);
                end else begin
                    chk("wbrw_ld", wb_reg_write, rw);
                    chk("wbdata_ld", wb_data, rdata >> (8 * off));
                    chk("wbf3_ld", wb_funct3, f3);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
        ex_valid = 0; ex_mem_read = 0; ex_mem_write = 0; ex_funct3 = 0;
        ex_addr = 0; ex_wdata = 0; ex_rd = 0; ex_reg_write = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wbv", wb_valid, 0);
        chk("rst_wbrw", wb_reg_write, 0);
        chk("rst_wbrd", wb_rd, 0);
        chk("rst_wbf3", wb_funct3, 0);
        chk("rst_wbdata", wb_data, 0);
        chk("rst_mis", misalign_exc, 0);
        chk("rst_to", timeout_exc, 0);
        chk("rst_stall", stall, 0);
        @(negedge clk) rst = 1'b0;

        do_op(1, 0, 0, 3'b010, 32'h0000_1234, 0, 5'd5, 1, 0, 0);            // ALU
        do_op(1, 1, 0, 3'b100, 32'h0000_0103, 0, 5'd7, 1, 32'hAABBCCDD, 3); // LBU
        do_op(1, 0, 1, 3'b001, 32'h0000_0022, 32'h0000_BEEF, 5'd3, 1, 0, 0); // SH
        do_op(1, 1, 0, 3'b010, 32'h0000_0006, 0, 5'd9, 1, 0, 0);            // LW misaligned
        do_op(1, 1, 0, 3'b010, 32'h0000_0040, 0, 5'd4, 1, 32'h1111_2222, 5); // timeout
        do_op(1, 1, 0, 3'b010, 32'h0000_0040, 0, 5'd4, 1, 32'h1111_2222, 4); // ack on last cycle
        do_op(1, 0, 1, 3'b000, 32'h0000_0013, 32'h0000_005A, 5'd1, 1, 0, 1); // SB off 3
        do_op(1, 1, 0, 3'b001, 32'h0000_0202, 0, 5'd2, 1, 32'h8765_4321, 2); // LH off 2
        do_op(1, 0, 1, 3'b011, 32'h0000_0000, 0, 5'd2, 1, 0, 0);            // unsupported store
        do_op(0, 0, 0, 3'b010, 32'h0000_0055, 0, 5'd6, 1, 0, 0);            // bubble

        // Reset in the middle of a pending load
        do_op(1, 0, 0, 3'b010, 32'h0000_0777, 0, 5'd8, 1, 0, 0);
        @(negedge clk);
        ex_valid = 1; ex_mem_read = 1; ex_mem_write = 0; ex_funct3 = 3'b010;
        ex_addr = 32'h80; ex_rd = 5'd10; ex_reg_write = 1; mem_ack = 0;
        #1 chk("rstb_stall0", stall, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstb_req", mem_req, 0);
        chk("rstb_stall", stall, 0);
        chk("rstb_wbv", wb_valid, 0);
        chk("rstb_wbrw", wb_reg_write, 0);
        @(negedge clk);
        rst = 1'b0; ex_valid = 0; mem_ack = 1;
        @(posedge clk); #1;
        chk("rstb_late_ack_wbv", wb_valid, 0);
        chk("rstb_late_ack_wbrw", wb_reg_write, 0);

        for (int n = 0; n < 150; n++) begin
            int kind;
            kind = $urandom_range(0, 3);
            do_op(($urandom % 8) != 0, kind == 1 || kind == 3, kind == 2 || kind == 3,
                  3'($urandom), $urandom, $urandom, 5'($urandom), 1'($urandom),
                  $urandom, $urandom_range(0, 6));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
